// File: rtl/spu_result_pipe.sv
// Result-delay pipeline for an SPU execution pipe: DEPTH-stage shift register with
// latency-based readiness, youngest-match forwarding lookup, partial flush and registered writeback.
module spu_result_pipe #(
  parameter int unsigned DATA_W     = 128,
  parameter int unsigned REG_W      = 7,
  parameter int unsigned UNIT_W     = 3,
  parameter int unsigned LAT_W      = 4,
  parameter int unsigned DEPTH      = 7,
  parameter int unsigned KILL_DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [UNIT_W-1:0]          in_unit_id,
  input  logic [DATA_W-1:0]          in_result,
  input  logic [REG_W-1:0]           in_reg_dst,
  input  logic [LAT_W-1:0]           in_latency,
  input  logic                       in_reg_wr,
  input  logic                       flush,
  input  logic [REG_W-1:0]           query_reg,
  output logic                       query_hit,
  output logic                       query_ready,
  output logic [DATA_W-1:0]          query_data,
  output logic [DEPTH-1:0]           fwd_valid,
  output logic [DEPTH-1:0]           fwd_ready,
  output logic [DEPTH*REG_W-1:0]     fwd_reg_dst,
  output logic [DEPTH*DATA_W-1:0]    fwd_data,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic                       wb_en,
  output logic [REG_W-1:0]           wb_addr,
  output logic [DATA_W-1:0]          wb_data,
  output logic [UNIT_W-1:0]          wb_unit_id
);

  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic              valid;
    logic              reg_wr;
    logic [UNIT_W-1:0] unit_id;
    logic [REG_W-1:0]  reg_dst;
    logic [LAT_W-1:0]  lat;
    logic [DATA_W-1:0] data;
  } stage_t;

  stage_t           st  [DEPTH];
  stage_t           nxt [DEPTH];
  logic [LAT_W-1:0] lat_eff;
  logic [OCC_W-1:0] occ_next;

  always_comb begin
    lat_eff = in_latency;
    if (in_latency == '0)
      lat_eff = LAT_W'(1);
    else if (32'(in_latency) > DEPTH)
      lat_eff = LAT_W'(DEPTH);
  end

  // Index k holds stage k+1; flush clears stage 1 and kills old stages 1..KILL_DEPTH-1.
  always_comb begin
    nxt[0] = '0;
    if (in_valid && !flush) begin
      nxt[0].valid   = 1'b1;
      nxt[0].reg_wr  = in_reg_wr;
      nxt[0].unit_id = in_unit_id;
      nxt[0].reg_dst = in_reg_dst;
      nxt[0].lat     = lat_eff;
      nxt[0].data    = in_result;
    end
    for (int unsigned k = 1; k < DEPTH; k++) begin
      if (flush && (k < KILL_DEPTH))
        nxt[k] = '0;
      else
        nxt[k] = st[k-1];
    end
  end

  always_comb begin
    occ_next = '0;
    for (int unsigned k = 0; k < DEPTH; k++)
      occ_next = occ_next + OCC_W'(nxt[k].valid);
  end

  always_comb begin
    fwd_valid   = '0;
    fwd_ready   = '0;
    fwd_reg_dst = '0;
    fwd_data    = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (st[k].valid) begin
        fwd_valid[k]                  = 1'b1;
        fwd_ready[k]                  = (32'(st[k].lat) <= (k + 1));
        fwd_reg_dst[k*REG_W +: REG_W] = st[k].reg_dst;
        fwd_data[k*DATA_W +: DATA_W]  = st[k].data;
      end
    end
  end

  // Scan oldest to youngest so the youngest matching stage is the final assignment.
  always_comb begin
    query_hit   = 1'b0;
    query_ready = 1'b0;
    query_data  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (st[DEPTH-1-i].valid && st[DEPTH-1-i].reg_wr &&
          (st[DEPTH-1-i].reg_dst == query_reg)) begin
        query_hit   = 1'b1;
        query_ready = fwd_ready[DEPTH-1-i];
        query_data  = st[DEPTH-1-i].data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < DEPTH; k++)
        st[k] <= '0;
      occupancy  <= '0;
      wb_en      <= 1'b0;
      wb_addr    <= '0;
      wb_data    <= '0;
      wb_unit_id <= '0;
    end else begin
      for (int unsigned k = 0; k < DEPTH; k++)
        st[k] <= nxt[k];
      occupancy <= occ_next;
      if (st[DEPTH-1].valid && st[DEPTH-1].reg_wr) begin
        wb_en      <= 1'b1;
        wb_addr    <= st[DEPTH-1].reg_dst;
        wb_data    <= st[DEPTH-1].data;
        wb_unit_id <= st[DEPTH-1].unit_id;
      end else begin
        wb_en      <= 1'b0;
        wb_addr    <= '0;
        wb_data    <= '0;
        wb_unit_id <= '0;
      end
    end
  end

endmodule

// File: tb/tb_spu_result_pipe.sv
// Directed self-checking bench for spu_result_pipe at default parameters (DEPTH=7, KILL_DEPTH=2).
module tb_spu_result_pipe;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [2:0]   in_unit_id;
  logic [127:0] in_result;
  logic [6:0]   in_reg_dst;
  logic [3:0]   in_latency;
  logic         in_reg_wr;
  logic         flush;
  logic [6:0]   query_reg;
  logic         query_hit;
  logic         query_ready;
  logic [127:0] query_data;
  logic [6:0]   fwd_valid;
  logic [6:0]   fwd_ready;
  logic [48:0]  fwd_reg_dst;
  logic [895:0] fwd_data;
  logic [2:0]   occupancy;
  logic         wb_en;
  logic [6:0]   wb_addr;
  logic [127:0] wb_data;
  logic [2:0]   wb_unit_id;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  spu_result_pipe #(
    .DATA_W(128), .REG_W(7), .UNIT_W(3), .LAT_W(4), .DEPTH(7), .KILL_DEPTH(2)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_unit_id(in_unit_id),
    .in_result(in_result), .in_reg_dst(in_reg_dst), .in_latency(in_latency),
    .in_reg_wr(in_reg_wr), .flush(flush), .query_reg(query_reg),
    .query_hit(query_hit), .query_ready(query_ready), .query_data(query_data),
    .fwd_valid(fwd_valid), .fwd_ready(fwd_ready), .fwd_reg_dst(fwd_reg_dst),
    .fwd_data(fwd_data), .occupancy(occupancy), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .wb_unit_id(wb_unit_id)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [6:0] r, input logic [127:0] d,
                       input logic [3:0] lat, input logic wr, input logic [2:0] u);
    in_valid   = v;
    in_reg_dst = r;
    in_result  = d;
    in_latency = lat;
    in_reg_wr  = wr;
    in_unit_id = u;
  endtask

  task automatic idle_drain(input int n);
    drive(1'b0, 7'd0, '0, 4'd0, 1'b0, 3'd0);
    flush = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 7'd0, '0, 4'd0, 1'b0, 3'd0);
    flush = 1'b0;
    query_reg = 7'd0;
    step();
    step();
    rst = 1'b0;
    idle_drain(10);
    n_cmp++; if (fwd_valid !== 7'd0) begin n_err++; $display("FAIL reset_fwd_valid: got %b want 0", fwd_valid); end
    n_cmp++; if (fwd_ready !== 7'd0) begin n_err++; $display("FAIL reset_fwd_ready: got %b want 0", fwd_ready); end
    n_cmp++; if (fwd_data !== '0) begin n_err++; $display("FAIL reset_fwd_data: nonzero, want 0"); end
    n_cmp++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL reset_occupancy: got %0d want 0", occupancy); end
    n_cmp++; if (wb_en !== 1'b0 || wb_addr !== 7'd0 || wb_data !== '0 || wb_unit_id !== 3'd0) begin
      n_err++; $display("FAIL reset_wb: en %b addr %0d unit %0d want all 0", wb_en, wb_addr, wb_unit_id); end
    n_cmp++; if (query_hit !== 1'b0 || query_ready !== 1'b0 || query_data !== '0) begin
      n_err++; $display("FAIL reset_query: hit %b ready %b want 0", query_hit, query_ready); end
  endtask

  task automatic test_single_issue();
    logic [127:0] a5;
    a5 = {16{8'hA5}};
    query_reg = 7'd5;
    drive(1'b1, 7'd5, a5, 4'd2, 1'b1, 3'd2);
    step();
    drive(1'b0, 7'd0, '0, 4'd0, 1'b0, 3'd0);
    n_cmp++; if (fwd_valid !== 7'b0000001) begin n_err++; $display("FAIL single_e1_valid: got %b want 0000001", fwd_valid); end
    n_cmp++; if (fwd_ready !== 7'b0000000) begin n_err++; $display("FAIL single_e1_ready: got %b want 0000000", fwd_ready); end
    n_cmp++; if (occupancy !== 3'd1) begin n_err++; $display("FAIL single_e1_occ: got %0d want 1", occupancy); end
    n_cmp++; if (query_hit !== 1'b1 || query_ready !== 1'b0 || query_data !== a5) begin
      n_err++; $display("FAIL single_e1_query: hit %b ready %b data %h want 1 0 %h", query_hit, query_ready, query_data, a5); end
    step();
    n_cmp++; if (fwd_ready !== 7'b0000010) begin n_err++; $display("FAIL single_e2_ready: got %b want 0000010", fwd_ready); end
    n_cmp++; if (query_ready !== 1'b1) begin n_err++; $display("FAIL single_e2_qready: got %b want 1", query_ready); end
    n_cmp++; if (fwd_data[1*128 +: 128] !== a5) begin n_err++; $display("FAIL single_e2_data: got %h want %h", fwd_data[1*128 +: 128], a5); end
    for (int i = 0; i < 5; i++) step();
    n_cmp++; if (fwd_valid !== 7'b1000000 || wb_en !== 1'b0) begin
      n_err++; $display("FAIL single_e7: valid %b wb_en %b want 1000000 0", fwd_valid, wb_en); end
    step();
    n_cmp++; if (wb_en !== 1'b1 || wb_addr !== 7'd5 || wb_data !== a5 || wb_unit_id !== 3'd2) begin
      n_err++; $display("FAIL single_e8_wb: en %b addr %0d unit %0d data %h want 1 5 2 %h", wb_en, wb_addr, wb_unit_id, wb_data, a5); end
    n_cmp++; if (fwd_valid !== 7'd0 || occupancy !== 3'd0) begin
      n_err++; $display("FAIL single_e8_empty: valid %b occ %0d want 0 0", fwd_valid, occupancy); end
    step();
    n_cmp++; if (wb_en !== 1'b0) begin n_err++; $display("FAIL single_e9_wb: got %b want 0", wb_en); end
    idle_drain(2);
  endtask

  task automatic test_youngest_match();
    query_reg = 7'd3;
    drive(1'b1, 7'd3, 128'd1, 4'd6, 1'b1, 3'd1);
    step();
    drive(1'b1, 7'd3, 128'd2, 4'd2, 1'b1, 3'd1);
    step();
    drive(1'b0, 7'd0, '0, 4'd0, 1'b0, 3'd0);
    n_cmp++; if (query_hit !== 1'b1 || query_data !== 128'd2 || query_ready !== 1'b0) begin
      n_err++; $display("FAIL young_e2: hit %b ready %b data %h want 1 0 2", query_hit, query_ready, query_data); end
    // third entry also targets r3 but does not write the register file
    drive(1'b1, 7'd3, 128'd3, 4'd1, 1'b0, 3'd1);
    step();
    drive(1'b0, 7'd0, '0, 4'd0, 1'b0, 3'd0);
    n_cmp++; if (query_hit !== 1'b1 || query_data !== 128'd2 || query_ready !== 1'b1) begin
      n_err++; $display("FAIL young_e3: hit %b ready %b data %h want 1 1 2", query_hit, query_ready, query_data); end
    n_cmp++; if (fwd_valid !== 7'b0000111 || fwd_ready !== 7'b0000011 || occupancy !== 3'd3) begin
      n_err++; $display("FAIL young_e3_vec: valid %b ready %b occ %0d want 0000111 0000011 3", fwd_valid, fwd_ready, occupancy); end
    query_reg = 7'd4;
    #1;
    n_cmp++; if (query_hit !== 1'b0 || query_ready !== 1'b0 || query_data !== '0) begin
      n_err++; $display("FAIL young_nohit: hit %b ready %b data %h want 0 0 0", query_hit, query_ready, query_data); end
    idle_drain(9);
  endtask

  task automatic test_flush();
    logic [6:0] seen [4];
    int         n_wb;
    drive(1'b1, 7'd10, 128'hA, 4'd1, 1'b1, 3'd0); step();
    drive(1'b1, 7'd11, 128'hB, 4'd1, 1'b1, 3'd0); step();
    drive(1'b1, 7'd12, 128'hC, 4'd1, 1'b1, 3'd0); step();
    drive(1'b1, 7'd13, 128'hD, 4'd1, 1'b1, 3'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 7'd0, '0, 4'd0, 1'b0, 3'd0);
    // C (old stage 1) and D are killed; B (old stage 2) moves past the kill window
    n_cmp++; if (fwd_valid !== 7'b0001100) begin n_err++; $display("FAIL flush_valid: got %b want 0001100", fwd_valid); end
    n_cmp++; if (occupancy !== 3'd2) begin n_err++; $display("FAIL flush_occ: got %0d want 2", occupancy); end
    n_cmp++; if (fwd_reg_dst[3*7 +: 7] !== 7'd10 || fwd_reg_dst[2*7 +: 7] !== 7'd11) begin
      n_err++; $display("FAIL flush_dst: s4 %0d s3 %0d want 10 11", fwd_reg_dst[3*7 +: 7], fwd_reg_dst[2*7 +: 7]); end
    n_cmp++; if (fwd_data[0 +: 256] !== '0) begin n_err++; $display("FAIL flush_bubble_data: stages 1-2 nonzero, want 0"); end
    n_wb = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (wb_en === 1'b1) begin
        if (n_wb < 4) seen[n_wb] = wb_addr;
        n_wb++;
      end
    end
    n_cmp++; if (n_wb !== 2) begin n_err++; $display("FAIL flush_wb_count: got %0d want 2", n_wb); end
    n_cmp++; if (n_wb >= 2 && (seen[0] !== 7'd10 || seen[1] !== 7'd11)) begin
      n_err++; $display("FAIL flush_wb_order: got %0d,%0d want 10,11", seen[0], seen[1]); end
  endtask

  task automatic test_latency_clamp();
    query_reg = 7'd20;
    drive(1'b1, 7'd20, 128'h20, 4'd0, 1'b1, 3'd3);
    step();
    drive(1'b0, 7'd0, '0, 4'd0, 1'b0, 3'd0);
    n_cmp++; if (fwd_ready !== 7'b0000001 || query_ready !== 1'b1) begin
      n_err++; $display("FAIL lat0_ready: vec %b q %b want 0000001 1", fwd_ready, query_ready); end
    idle_drain(8);
    drive(1'b1, 7'd21, 128'h21, 4'd15, 1'b1, 3'd3);
    for (int k = 1; k <= 7; k++) begin
      step();
      drive(1'b0, 7'd0, '0, 4'd0, 1'b0, 3'd0);
      n_cmp++;
      if (fwd_ready !== ((k == 7) ? 7'b1000000 : 7'b0000000)) begin
        n_err++; $display("FAIL lat15_stage%0d: got %b want ready only at stage 7", k, fwd_ready); end
    end
    idle_drain(3);
  endtask

  task automatic test_reset_mid();
    int n_wb;
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 7'(30 + i), 128'(100 + i), 4'd1, 1'b1, 3'd4);
      step();
    end
    drive(1'b0, 7'd0, '0, 4'd0, 1'b0, 3'd0);
    n_cmp++; if (fwd_valid !== 7'b1111111 || occupancy !== 3'd7) begin
      n_err++; $display("FAIL full_pipe: valid %b occ %0d want 1111111 7", fwd_valid, occupancy); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++; if (fwd_valid !== 7'd0 || occupancy !== 3'd0 || wb_en !== 1'b0 || fwd_data !== '0) begin
      n_err++; $display("FAIL midreset_clear: valid %b occ %0d wb_en %b want 0 0 0", fwd_valid, occupancy, wb_en); end
    n_wb = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (wb_en !== 1'b0) n_wb++;
    end
    n_cmp++; if (n_wb !== 0) begin n_err++; $display("FAIL midreset_late_wb: got %0d writebacks want 0", n_wb); end
  endtask

  initial begin
    test_reset();
    test_single_issue();
    test_youngest_match();
    test_flush();
    test_latency_clamp();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
